// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction classes, opcode/funct constants and datapath select codes.
//
// Optional feature macro: MC_BEQ_EN (enables opcode 0x04 as BEQ).
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,  // ADD/SUB/SLT
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_JMP = 3'd3,  // J/JAL/JR
        CLS_BR  = 3'd4,  // BNE (and BEQ when enabled)
        CLS_IMM = 3'd5   // XORI
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_XOR   = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_REG    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // Register-file data-in selects
    localparam logic [1:0] DIN_LINK = 2'b00;
    localparam logic [1:0] DIN_MEM  = 2'b01;
    localparam logic [1:0] DIN_ALU  = 2'b10;

    // Register-file write-address selects
    localparam logic [1:0] WADR_00 = 2'b00;
    localparam logic [1:0] WADR_10 = 2'b10;

endpackage

// File: rtl/multicycle_controller_mc_decode.sv
// mc_decode: combinational legality check and instruction class decode.
//   opcode, funct : IR fields
//   legal         : instruction is in the supported set
//   cls           : instruction class (R/LW/SW/JMP/BR/IMM)
//   is_jal/is_jr  : refine the JMP class (link write / register target)
//   is_beq        : refine the BR class (branch on equal)
// Optional feature macro: MC_BEQ_EN.
module mc_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output cls_t       cls,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_beq
);

    always_comb begin
        legal  = 1'b1;
        cls    = CLS_R;
        is_jal = 1'b0;
        is_jr  = 1'b0;
        is_beq = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT: cls = CLS_R;
                    FN_JR: begin
                        cls   = CLS_JMP;
                        is_jr = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_J:    cls = CLS_JMP;
            OP_JAL: begin
                cls    = CLS_JMP;
                is_jal = 1'b1;
            end
            OP_BNE:  cls = CLS_BR;
            OP_XORI: cls = CLS_IMM;
`ifdef MC_BEQ_EN
            OP_BEQ: begin
                cls    = CLS_BR;
                is_beq = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with a
// memory-wait watchdog, sticky trap state and retired-instruction counter.
//   clk, reset         : clock, asynchronous active-high reset
//   opcode, funct      : IR fields, stable from DECODE to the next FETCH
//   mem_ready, zero    : memory handshake, ALU equal flag
//   mem_req            : memory request, held until mem_ready
//   pc_wen, ir_wen     : PC / IR write strobes
//   sel_pc .. rf_seldin: datapath controls
//   state, trap        : current FSM state, sticky fault flag
//   retired            : completed instructions, wraps
// Optional feature macro: MC_BEQ_EN (opcode 0x04 legal, branches on zero).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int RET_CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 mem_req,
    output logic                 pc_wen,
    output logic                 ir_wen,
    output logic [1:0]           sel_pc,
    output logic                 sgn,
    output logic                 sel_b,
    output logic [1:0]           sel_aluop,
    output logic                 dm_wen,
    output logic                 rf_wen,
    output logic [1:0]           rf_selwadr,
    output logic [1:0]           rf_seldin,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [RET_CNT_W-1:0] retired
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
    localparam logic [RET_CNT_W-1:0] RET_ONE = {{(RET_CNT_W-1){1'b0}}, 1'b1};

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       legal, is_jal, is_jr, is_beq;
    cls_t       cls;
    logic       retire;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .legal  (legal),
        .cls    (cls),
        .is_jal (is_jal),
        .is_jr  (is_jr),
        .is_beq (is_beq)
    );

    // Wait counter only advances while a FETCH/MEM access is outstanding;
    // every other cycle clears it, so each new FETCH/MEM entry starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= ST_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            wait_cnt <= '0;
            if (retire) retired <= retired + RET_ONE;
            case (cur)
                ST_FETCH, ST_MEM: begin
                    if (mem_ready) begin
                        if (cur == ST_FETCH)  cur <= ST_DECODE;
                        else if (cls == CLS_LW) cur <= ST_WB;
                        else                  cur <= ST_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: cur <= legal ? ST_EXEC : ST_TRAP;
                ST_EXEC: begin
                    case (cls)
                        CLS_LW, CLS_SW:  cur <= ST_MEM;
                        CLS_R, CLS_IMM:  cur <= ST_WB;
                        default:         cur <= ST_FETCH;
                    endcase
                end
                ST_WB:   cur <= ST_FETCH;
                ST_TRAP: cur <= ST_TRAP;
                default: cur <= ST_TRAP;
            endcase
        end
    end

    // Outputs decode from the current state (plus mem_ready/zero where the
    // action depends on them); everything defaults to 0 and is forced off
    // while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        pc_wen     = 1'b0;
        ir_wen     = 1'b0;
        sel_pc     = PC_PLUS4;
        sgn        = 1'b0;
        sel_b      = 1'b0;
        sel_aluop  = ALU_ADD;
        dm_wen     = 1'b0;
        rf_wen     = 1'b0;
        rf_selwadr = WADR_00;
        rf_seldin  = DIN_LINK;
        retire     = 1'b0;
        if (!reset) begin
            case (cur)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_wen = 1'b1;
                        pc_wen = 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_R: sel_aluop = ALU_RTYPE;
                        CLS_LW, CLS_SW: begin
                            sel_b = 1'b1;
                            sgn   = 1'b1;
                        end
                        CLS_IMM: begin
                            sel_aluop = ALU_XOR;
                            sel_b     = 1'b1;
                        end
                        CLS_JMP: begin
                            pc_wen = 1'b1;
                            sel_pc = is_jr ? PC_REG : PC_JUMP;
                            retire = 1'b1;
                            if (is_jal) begin
                                rf_wen     = 1'b1;
                                rf_selwadr = WADR_10;
                                rf_seldin  = DIN_LINK;
                            end
                        end
                        CLS_BR: begin
                            sel_pc = PC_BRANCH;
                            pc_wen = is_beq ? zero : ~zero;
                            retire = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    dm_wen  = (cls == CLS_SW);
                    retire  = mem_ready && (cls == CLS_SW);
                end
                ST_WB: begin
                    rf_wen = 1'b1;
                    retire = 1'b1;
                    case (cls)
                        CLS_R: begin
                            rf_selwadr = WADR_10;
                            rf_seldin  = DIN_ALU;
                        end
                        CLS_LW:  rf_seldin = DIN_MEM;
                        default: rf_seldin = DIN_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state = cur;
    assign trap  = (cur == ST_TRAP);

endmodule
